// File: rtl/gorev4_cdf_lut.sv
// Histogram-equalisation LUT builder: accumulates 256 bin counts into a CDF, then emits
// a 256-entry grey-level remap table. Optional total-count check: GOREV4_CDF_TOPLAM_KONTROL_EN.
module gorev4_cdf_lut #(
  parameter int PIXELS = 76800,
  parameter int CW     = 32,
  parameter int SW     = $clog2(PIXELS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [CW-1:0] veri_i,
  input  logic          veri_gecerli_i,
  output logic          veri_al_o,
  output logic [7:0]    lut_o,
  output logic [7:0]    lut_addr_o,
  output logic          lut_gecerli_o,
  input  logic          lut_hazir_i,
  output logic          islem_bitti_o,
  output logic          hata_o
);

  localparam int PW = SW + 8;
  localparam int CYW = $clog2(PW + 1);

  typedef enum logic [2:0] {IDLE, TOPLA, KONTROL, HESAP, CIKIS, BITTI} state_t;

  state_t          state_q, state_d;
  logic [7:0]      bin_cnt_q;
  logic [SW-1:0]   sum_q;
  logic [SW-1:0]   cdf_min_q;
  logic            min_bulundu_q;
  logic [SW-1:0]   payda_q;
  logic [7:0]      k_q;
  logic [CYW-1:0]  cyc_q;
  logic [PW-1:0]   quo_q;
  logic [SW:0]     rem_q;
  logic [7:0]      lut_q;
  logic [SW-1:0]   cdf_mem [256];

  logic            accept_bin;
  logic [SW-1:0]   sum_next;
  logic [SW-1:0]   cdf_k;
  logic [SW-1:0]   diff;
  logic [PW-1:0]   pay;
  logic [SW:0]     rem_sh;
  logic            ge;
  logic [SW:0]     rem_n;
  logic [PW-1:0]   quo_n;
  logic [7:0]      quo_sat;

  assign accept_bin = (state_q == TOPLA) && veri_gecerli_i;
  assign sum_next   = sum_q + veri_i[SW-1:0];
  assign cdf_k      = cdf_mem[k_q];
  assign diff       = cdf_k - cdf_min_q;

  // Rounded numerator; bins below the first nonzero level map to zero
  always_comb begin
    pay = '0;
    if (cdf_k >= cdf_min_q)
      pay = ({{(PW-SW){1'b0}}, diff} * PW'(255)) + {{(PW-SW+1){1'b0}}, payda_q[SW-1:1]};
  end

  // One restoring-division step: dividend bits shift out of quo_q as quotient bits shift in
  assign rem_sh  = {rem_q[SW-1:0], quo_q[PW-1]};
  assign ge      = rem_sh >= {1'b0, payda_q};
  assign rem_n   = ge ? (rem_sh - {1'b0, payda_q}) : rem_sh;
  assign quo_n   = {quo_q[PW-2:0], ge};
  assign quo_sat = (|quo_n[PW-1:8]) ? 8'hFF : quo_n[7:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = TOPLA;
      TOPLA:   if (accept_bin && (bin_cnt_q == 8'd255)) state_d = KONTROL;
      KONTROL: begin
        state_d = HESAP;
`ifdef GOREV4_CDF_TOPLAM_KONTROL_EN
        if (sum_q != SW'(PIXELS)) state_d = BITTI;
`endif
      end
      HESAP:   if (cyc_q == CYW'(PW)) state_d = CIKIS;
      CIKIS:   if (lut_hazir_i) state_d = (k_q == 8'd255) ? BITTI : HESAP;
      BITTI:   if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bin_cnt_q     <= '0;
      sum_q         <= '0;
      cdf_min_q     <= '0;
      min_bulundu_q <= 1'b0;
      payda_q       <= '0;
      k_q           <= '0;
      cyc_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      lut_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i) begin
            bin_cnt_q     <= '0;
            sum_q         <= '0;
            cdf_min_q     <= '0;
            min_bulundu_q <= 1'b0;
          end
        end
        TOPLA: begin
          if (accept_bin) begin
            sum_q     <= sum_next;
            bin_cnt_q <= bin_cnt_q + 8'd1;
            if (!min_bulundu_q && (|veri_i)) begin
              cdf_min_q     <= sum_next;
              min_bulundu_q <= 1'b1;
            end
          end
        end
        KONTROL: begin
          payda_q <= sum_q - cdf_min_q;
          k_q     <= '0;
          cyc_q   <= '0;
        end
        HESAP: begin
          cyc_q <= cyc_q + 1'b1;
          if (cyc_q == '0) begin
            quo_q <= pay;
            rem_q <= '0;
          end else begin
            quo_q <= quo_n;
            rem_q <= rem_n;
          end
          if (cyc_q == CYW'(PW))
            lut_q <= (payda_q == '0) ? k_q : quo_sat;
        end
        CIKIS: begin
          if (lut_hazir_i) begin
            cyc_q <= '0;
            if (k_q != 8'd255) k_q <= k_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_bin) cdf_mem[bin_cnt_q] <= sum_next;
  end

`ifdef GOREV4_CDF_TOPLAM_KONTROL_EN
  logic hata_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      hata_q <= 1'b0;
    else if ((state_q == KONTROL) && (sum_q != SW'(PIXELS)))
      hata_q <= 1'b1;
    else if ((state_q == BITTI) && !en_i)
      hata_q <= 1'b0;
  end

  assign hata_o = hata_q;
`else
  assign hata_o = 1'b0;
`endif

  assign veri_al_o     = (state_q == TOPLA);
  assign lut_gecerli_o = (state_q == CIKIS);
  assign islem_bitti_o = (state_q == BITTI);
  assign lut_o         = lut_q;
  assign lut_addr_o    = k_q;

endmodule

// File: tb/tb_gorev4_cdf_lut.sv
// Scoreboard bench for gorev4_cdf_lut: directed histograms with hand-computed LUTs,
// entry timing, back-pressure stall and mid-frame reset.
module tb_gorev4_cdf_lut;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [31:0] veri_i;
  logic        veri_gecerli_i;
  logic        veri_al_o;
  logic [7:0]  lut_o;
  logic [7:0]  lut_addr_o;
  logic        lut_gecerli_o;
  logic        lut_hazir_i;
  logic        islem_bitti_o;
  logic        hata_o;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] expQ [$];
  int unsigned hist [256];
  logic [7:0]  expTab [256];
  bit          bpArm = 1'b0;

  int          binCnt = 0;
  int          lastBinEdge = 0;
  int          lastAcceptEdge = 0;
  bit          prevValid = 1'b0;
  bit          expectFirst = 1'b0;

  gorev4_cdf_lut dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .veri_i         (veri_i),
    .veri_gecerli_i (veri_gecerli_i),
    .veri_al_o      (veri_al_o),
    .lut_o          (lut_o),
    .lut_addr_o     (lut_addr_o),
    .lut_gecerli_o  (lut_gecerli_o),
    .lut_hazir_i    (lut_hazir_i),
    .islem_bitti_o  (islem_bitti_o),
    .hata_o         (hata_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset veri_al_o", int'(veri_al_o), 0);
    checkOutput("reset lut_o", int'(lut_o), 0);
    checkOutput("reset lut_addr_o", int'(lut_addr_o), 0);
    checkOutput("reset lut_gecerli_o", int'(lut_gecerli_o), 0);
    checkOutput("reset islem_bitti_o", int'(islem_bitti_o), 0);
    checkOutput("reset hata_o", int'(hata_o), 0);
  endtask

  task automatic fillUniform();
    for (int k = 0; k < 256; k++) begin
      hist[k]   = 300;
      expTab[k] = 8'(k);
    end
  endtask

  // Drives one frame of bins and, unless aborted by reset, waits for BITTI
  task automatic applyStimulus(input bit withEntries, input int abortAt, input bit expHata);
    int t;
    if (withEntries)
      for (int k = 0; k < 256; k++) expQ.push_back({8'(k), expTab[k]});
    @(posedge clk_i); #1;
    en_i = 1'b1;
    for (int k = 0; k < 256; k++) begin
      if ((k % 64) == 63) begin
        veri_gecerli_i = 1'b0;
        @(posedge clk_i); #1;
      end
      veri_i = hist[k];
      veri_gecerli_i = 1'b1;
      t = 0;
      @(negedge clk_i);
      while (!veri_al_o && t < 100) begin
        @(negedge clk_i);
        t++;
      end
      if (!veri_al_o) checkOutput("bin accept timeout", 0, 1);
      @(posedge clk_i); #1;
    end
    veri_gecerli_i = 1'b0;
    veri_i = '0;
    if (abortAt >= 0) begin
      t = 0;
      while (!((int'(lut_addr_o) == abortAt) && !lut_gecerli_o) && t < 20000) begin
        @(posedge clk_i); #1;
        t++;
      end
      checkOutput("abort point lut_addr_o", int'(lut_addr_o), abortAt);
      repeat (5) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      en_i  = 1'b0;
      #1;
      checkResetOutputs();
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
    end else begin
      t = 0;
      while (!islem_bitti_o && t < 9000) begin
        @(posedge clk_i); #1;
        t++;
      end
      checkOutput("islem_bitti_o at end", int'(islem_bitti_o), 1);
      checkOutput("hata_o at end", int'(hata_o), int'(expHata));
      checkOutput("entries outstanding", expQ.size(), 0);
      en_i = 1'b0;
      @(posedge clk_i); #1;
      checkOutput("islem_bitti_o after en low", int'(islem_bitti_o), 0);
      checkOutput("hata_o after BITTI", int'(hata_o), 0);
    end
  endtask

  // Monitor: compares every valid cycle against the queue head, pops on handshake
  always @(negedge clk_i) begin
    if (!rst_i) begin
      expQ.delete();
      binCnt      = 0;
      prevValid   = 1'b0;
      expectFirst = 1'b0;
    end else begin
      if (veri_gecerli_i && veri_al_o) begin
        if (binCnt == 255) begin
          lastBinEdge = cyc + 1;
          expectFirst = 1'b1;
        end
        binCnt = (binCnt + 1) % 256;
      end
      if (lut_gecerli_o) begin
        if (!prevValid) begin
          if (expectFirst) checkOutput("first entry latency", cyc - lastBinEdge, 27);
          else             checkOutput("entry spacing", cyc - lastAcceptEdge, 26);
        end
        if (expQ.size() == 0) begin
          checkOutput("unexpected entry", 1, 0);
        end else begin
          checkOutput("lut_addr_o", int'(lut_addr_o), int'(expQ[0][15:8]));
          checkOutput("lut_o", int'(lut_o), int'(expQ[0][7:0]));
        end
        if (lut_hazir_i) begin
          if (expQ.size() != 0) void'(expQ.pop_front());
          lastAcceptEdge = cyc + 1;
          expectFirst    = 1'b0;
        end
      end
      prevValid = lut_gecerli_o;
    end
  end

  // Downstream ready: one 10-cycle stall while entry 5 is presented
  initial begin
    lut_hazir_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      if (bpArm && lut_gecerli_o && (lut_addr_o == 8'd5)) begin
        lut_hazir_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        lut_hazir_i = 1'b1;
        bpArm = 1'b0;
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b0;
    en_i = 1'b0;
    veri_gecerli_i = 1'b0;
    veri_i = '0;
    #2;
    checkResetOutputs();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("veri_al_o in IDLE", int'(veri_al_o), 0);

    $display("[TB] uniform histogram");
    fillUniform();
    applyStimulus(1'b1, -1, 1'b0);

    $display("[TB] two-level image");
    for (int k = 0; k < 256; k++) begin
      hist[k]   = 0;
      expTab[k] = (k == 255) ? 8'd255 : 8'd0;
    end
    hist[0]   = 38400;
    hist[255] = 38400;
    applyStimulus(1'b1, -1, 1'b0);

    $display("[TB] single-level image");
    for (int k = 0; k < 256; k++) begin
      hist[k]   = 0;
      expTab[k] = 8'(k);
    end
    hist[100] = 76800;
    applyStimulus(1'b1, -1, 1'b0);

    $display("[TB] back-pressure on entry 5");
    fillUniform();
    bpArm = 1'b1;
    applyStimulus(1'b1, -1, 1'b0);

    $display("[TB] total 76799");
    fillUniform();
    hist[0] = 299;
`ifdef GOREV4_CDF_TOPLAM_KONTROL_EN
    applyStimulus(1'b0, -1, 1'b1);
`else
    applyStimulus(1'b1, -1, 1'b0);
`endif

    $display("[TB] reset during k=40");
    fillUniform();
    applyStimulus(1'b1, 40, 1'b0);

    $display("[TB] fresh uniform frame after reset");
    fillUniform();
    applyStimulus(1'b1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gorev4_cdf_lut.md
# gorev4_cdf_lut

Histogram-equalisation LUT builder sitting directly downstream of the gorev4 histogram table stage. It consumes the 256 × 32-bit bin counts streamed out after histogram accumulation and builds the cumulative distribution internally. It then produces a 256-entry, 8-bit grey-level remapping table, emitted in order for k = 0..255, which the next stage uses to rewrite the 76800-pixel image.

## Interface
- `PIXELS`, 76800: expected total pixel count.
- `CW`, 32: input bin-count width.
- `SW`, 17: cumulative-sum width (ceil(log2(PIXELS+1))).
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `en_i` in 1: start level; sampled only in IDLE.
- `veri_i` in CW: histogram bin count, bins arrive in order 0..255.
- `veri_gecerli_i` in 1: `veri_i` valid.
- `veri_al_o` out 1: ready for a bin; a bin is accepted when `veri_gecerli_i` and `veri_al_o` are both high.
- `lut_o` out 8: remapped grey level for `lut_addr_o`.
- `lut_addr_o` out 8: LUT index k.
- `lut_gecerli_o` out 1: `lut_o` and `lut_addr_o` valid.
- `lut_hazir_i` in 1: downstream ready; an entry is accepted when `lut_gecerli_o` and `lut_hazir_i` are both high.
- `islem_bitti_o` out 1: high while in BITTI.
- `hata_o` out 1: total-count mismatch (see Configuration).

## Operation
- **States:** IDLE, TOPLA, KONTROL, HESAP, CIKIS, BITTI.
- **IDLE:**
  - `en_i`=1 → TOPLA. Bin counter, running sum, `cdf_min` and `min_bulundu` are cleared.
- **TOPLA:**
  - `veri_al_o`=1.
  - Each accepted bin: running sum += `veri_i` (truncated to SW bits). The new sum is written to internal `cdf_mem[k]` (256 × SW).
  - The first bin with a nonzero count latches `cdf_min` = the new sum and sets `min_bulundu`.
  - After bin 255 is accepted → KONTROL; `veri_al_o` drops the same cycle.
- **KONTROL (1 cycle):**
  - `toplam` = `cdf_mem[255]`.
  - `payda` = `toplam` − `cdf_min`.
  - k = 0 → HESAP.
- **HESAP:**
  - Cycle 0: read `cdf_mem[k]`; `pay` = (`cdf[k]` − `cdf_min`) × 255 + (`payda` >> 1), 25 bits.
  - Cycles 1..25: restoring divide `pay` / `payda`, one quotient bit per cycle.
  - Quotient saturates to 255 → `lut_o`; then → CIKIS.
  - If `cdf[k]` < `cdf_min`, numerator = 0.
  - If `payda` = 0 (empty or single-level image), `lut_o` = k (identity) and the divider is bypassed; HESAP still lasts 26 cycles.
- **CIKIS:**
  - `lut_gecerli_o`=1.
  - `lut_o` and `lut_addr_o` are held stable until accepted.
  - On accept: k = 255 → BITTI, else k+1 → HESAP.
- **BITTI:**
  - `islem_bitti_o`=1.
  - Returns to IDLE when `en_i`=0.
- **`en_i` deassertion** outside IDLE/BITTI is ignored; a frame always completes.
- **Arithmetic:** all unsigned. `cdf_min` = 0 when no nonzero bin exists.

## Timing
- **Reset values:** all outputs 0; state IDLE; counters 0. `cdf_mem` contents are don't-care.
- **Reset mid-frame** aborts immediately; no partial LUT entries follow.
- **Input side:** `veri_al_o` rises the cycle after IDLE→TOPLA. Full input rate is 1 bin per cycle (256 cycles minimum).
- **Output latency:** `lut_gecerli_o` rises exactly 26 cycles after HESAP entry. Entry 0 appears 27 cycles after the last bin is accepted.
- **Output throughput:** minimum spacing is 27 cycles per entry with `lut_hazir_i` tied high.
- **BITTI** is entered the cycle after entry 255 is accepted.
- **Back-pressure:** an arbitrary-length low on `lut_hazir_i` stalls CIKIS with no data change.

## Configuration
- **`GOREV4_CDF_TOPLAM_KONTROL_EN` defined:**
  - In KONTROL, `toplam` ≠ `PIXELS` sets `hata_o`=1 and goes directly to BITTI. No LUT entries are emitted.
  - `hata_o` clears on leaving BITTI.
- **Undefined:**
  - `hata_o` is tied 0.
  - The LUT is always built using the measured `toplam`.

## Test plan
- **Uniform histogram:** 300 in every bin → `cdf_min`=300, `payda`=76500; `lut_o`=k for all k; `hata_o`=0.
- **Two-level image:** 38400 in bin 0 and 38400 in bin 255, others 0 → entries 0..254 = 0, entry 255 = 255.
- **Single-level image:** 76800 in bin 100 → `payda`=0, `lut_o`=k for all k. Each entry still arrives at 27-cycle spacing.
- **Back-pressure:** `lut_hazir_i` low for 10 cycles while `lut_addr_o`=5 → `lut_o` and `lut_addr_o` constant. Entry 6 appears 26 cycles after accept.
- **Macro defined:** counts summing to 76799 → `hata_o`=1, `islem_bitti_o`=1, `lut_gecerli_o` never asserts. Macro undefined, same input: 256 entries are emitted.
- **Reset mid-frame:** assert `rst_i` low during HESAP of k=40 → all outputs 0 asynchronously. A fresh uniform frame then reproduces the uniform result.
